sram_resp: RTL and testbench

Memory-side responder for the LSU load/store port: accepts one read or write request at a time over a valid/ready handshake, holds it for a fixed access latency, and returns read data or a write acknowledgement over a second valid/ready handshake. It replaces the zero-latency combinational SRAM model behind the LSU, so the core can be exercised against realistic multi-cycle memory timing.

---
 rtl/sram_resp_if.sv | 25 ++
 rtl/sram_resp.sv | 126 ++++++++++++
 tb/tb_sram_resp.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_resp_if.sv
// LSU load/store port bundle: request handshake plus response handshake.
// The requester drives the master side, the memory responder the slave side.
interface sram_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_size, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_size, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/sram_resp.sv
// Single-outstanding SRAM responder with a fixed access latency between request
// acceptance and response; storage is updated on the BUSY->RESP transition only.
module sram_resp #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    sram_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [1:0]  lane;
    logic [AW-1:0] index;
    logic        acc_err;
    logic        commit;
    logic [31:0] rd_shift, rd_sized;
    logic [3:0]  be;
    logic [31:0] wd_shift;

    // Addresses below BASE wrap to huge offsets and fail the range test.
    assign offset   = addr_q - BASE;
    assign lane     = addr_q[1:0];
    assign index    = offset[AW+1:2];
    assign acc_err  = (offset >= 32'(4 * DEPTH)) || (size_q == 2'd3) ||
                      (size_q == 2'd1 && lane[0]) || (size_q == 2'd2 && lane != 2'd0);
    assign commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign rd_shift = mem[index] >> {lane, 3'b000};
    assign be       = wmask_q << lane;
    assign wd_shift = wdata_q << {lane, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    rd_sized = {24'd0, rd_shift[7:0]};
            2'd1:    rd_sized = {16'd0, rd_shift[15:0]};
            default: rd_sized = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                wen_d   = bus.req_wen;
                addr_d  = bus.req_addr;
                size_d  = bus.req_size;
                wdata_d = bus.req_wdata;
                wmask_d = bus.req_wmask[3:0];
                cnt_d   = 4'(LATENCY - 1);
                state_d = S_BUSY;
            end
            S_BUSY: if (cnt_q == 4'd0) begin
                state_d = S_RESP;
                err_d   = acc_err;
                rdata_d = (acc_err || wen_q) ? 32'd0 : rd_sized;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            S_RESP: if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; reset forces IDLE, so an uncommitted write never lands.
    always_ff @(posedge clk) begin
        if (commit && wen_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[index][8*b +: 8] <= wd_shift[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: three instances (LATENCY 2, 1, 15) behind one shared driver,
// directed vector table, hand sequences for reset/backpressure/spacing, random vs byte model.
module tb_sram_resp;
    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  sel = 2'd0;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic [7:0]  req_wmask = '0;

    logic [2:0]        rr, rv, re;
    logic [2:0][31:0]  rd;
    logic              ready_m, valid_m, err_m;
    logic [31:0]       rdata_m;

    sram_resp_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req_valid  = req_valid && (sel == 2'(g));
        assign bus[g].req_wen    = req_wen;
        assign bus[g].req_addr   = req_addr;
        assign bus[g].req_size   = req_size;
        assign bus[g].req_wdata  = req_wdata;
        assign bus[g].req_wmask  = req_wmask;
        assign bus[g].resp_ready = resp_ready && (sel == 2'(g));
        assign rr[g] = bus[g].req_ready;
        assign rv[g] = bus[g].resp_valid;
        assign re[g] = bus[g].resp_err;
        assign rd[g] = bus[g].resp_rdata;
        sram_resp #(
            .DEPTH(DEPTH), .BASE(BASE),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus[g])
        );
    end

    assign ready_m = rr[sel];
    assign valid_m = rv[sel];
    assign err_m   = re[sel];
    assign rdata_m = rd[sel];

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 2 : ((s == 2'd1) ? 1 : 15);
    endfunction

    // Byte-addressed reference storage, one image per instance.
    bit [7:0] mb [3][4*DEPTH];

    function automatic void model(input logic [1:0] s, input logic w, input logic [31:0] a,
                                  input logic [1:0] sz, input logic [31:0] wd, input logic [7:0] wm,
                                  output logic [31:0] r, output logic e);
        int unsigned off, ln, nb;
        off = a - BASE;
        ln  = a % 4;
        nb  = 1 << sz;
        e   = (off >= 4 * DEPTH) || (sz == 2'd3) || ((ln % nb) != 0);
        r   = '0;
        if (e) return;
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (wm[i] && (ln + i) < 4) mb[s][off + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < int'(nb); i++) r[8*i +: 8] = mb[s][off + i];
        end
    endfunction

    // Called at posedge+1; returns response fields and edges from acceptance to resp_valid.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input logic [7:0] wm, input logic early,
                          output logic [31:0] r, output logic e, output int lat);
        bit ok;
        r = 'x; e = 1'bx; lat = -1; ok = 0;
        req_valid = 1'b1; req_wen = w; req_addr = a; req_size = sz;
        req_wdata = wd; req_wmask = wm; resp_ready = early;
        for (int k = 0; k < 50; k++) begin
            if (ready_m) begin
                @(posedge clk); #1; ok = 1; break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) begin chk("accept_timeout", 0, 1); return; end
        ok = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (valid_m) begin lat = k; ok = 1; break; end
        end
        if (!ok) begin chk("resp_timeout", 0, 1); return; end
        r = rdata_m; e = err_m;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("post_handshake_valid_ready", {30'd0, valid_m, ready_m}, 32'h1);
    endtask

    task automatic run(input string nm, input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, input logic [7:0] wm, input logic early);
        logic [31:0] mr, r;
        logic me, e;
        int lat;
        model(sel, w, a, sz, wd, wm, mr, me);
        do_txn(w, a, sz, wd, wm, early, r, e, lat);
        chk({nm, "_rdata"}, r, mr);
        chk({nm, "_err"}, {31'd0, e}, {31'd0, me});
        chk({nm, "_lat"}, lat, lat_of(sel));
    endtask

    // Back-to-back reads with req_valid and resp_ready held high.
    task automatic b2b(input logic [1:0] s);
        int acc[$];
        int lows[$];
        int low, L;
        L = lat_of(s);
        sel = s; low = 0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 4; req_size = 2'd2; resp_ready = 1'b1;
        for (int k = 0; k < 3 * (L + 2) + 4 && acc.size() < 3; k++) begin
            if (ready_m) begin
                if (acc.size() > 0) lows.push_back(low);
                acc.push_back(k);
                low = 0;
            end else begin
                low++;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (acc.size() < 3) begin
            chk("b2b_accepts", acc.size(), 3);
        end else begin
            chk("b2b_accept_spacing0", acc[1] - acc[0], L + 2);
            chk("b2b_accept_spacing1", acc[2] - acc[1], L + 2);
            chk("b2b_not_ready_cycles", lows[0], L + 1);
        end
        repeat (L + 3) @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, r0, mr;
        logic e, me;
        int lat, n;
        bit ok;

        tbl = '{
            '{1'b1, BASE,                  2'd2, 32'h11223344, 8'hF, 32'h0,        1'b0},
            '{1'b1, BASE + 8,              2'd2, 32'hDEADBEEF, 8'hF, 32'h0,        1'b0},
            '{1'b0, BASE + 8,              2'd2, 32'h0,        8'h0, 32'hDEADBEEF, 1'b0},
            '{1'b1, BASE + 9,              2'd0, 32'h0000005A, 8'h1, 32'h0,        1'b0},
            '{1'b0, BASE + 8,              2'd2, 32'h0,        8'h0, 32'hDEAD5AEF, 1'b0},
            '{1'b0, BASE + 10,             2'd1, 32'h0,        8'h0, 32'h0000DEAD, 1'b0},
            '{1'b0, BASE + 11,             2'd0, 32'h0,        8'h0, 32'h000000DE, 1'b0},
            '{1'b0, BASE - 4,              2'd2, 32'h0,        8'h0, 32'h0,        1'b1},
            '{1'b0, BASE + 4 * DEPTH,      2'd2, 32'h0,        8'h0, 32'h0,        1'b1},
            '{1'b0, BASE + 1,              2'd1, 32'h0,        8'h0, 32'h0,        1'b1},
            '{1'b0, BASE + 2,              2'd2, 32'h0,        8'h0, 32'h0,        1'b1},
            '{1'b0, BASE + 8,              2'd3, 32'h0,        8'h0, 32'h0,        1'b1},
            '{1'b1, BASE + 4 * DEPTH,      2'd2, 32'hFFFFFFFF, 8'hF, 32'h0,        1'b1},
            '{1'b0, BASE,                  2'd2, 32'h0,        8'h0, 32'h11223344, 1'b0},
            '{1'b1, BASE + 6,              2'd1, 32'h0000ABCD, 8'h3, 32'h0,        1'b0},
            '{1'b0, BASE + 6,              2'd1, 32'h0,        8'h0, 32'h0000ABCD, 1'b0},
            '{1'b1, BASE + 11,             2'd0, 32'h77665544, 8'hF, 32'h0,        1'b0},
            '{1'b0, BASE + 8,              2'd2, 32'h0,        8'h0, 32'h44AD5AEF, 1'b0}
        };

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_ready", {30'd0, valid_m, ready_m}, 32'h1);
        chk("reset_rdata", rdata_m, 32'h0);
        chk("reset_err", {31'd0, err_m}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on the LATENCY=2 instance
        sel = 2'd0;
        foreach (tbl[i]) begin
            model(2'd0, tbl[i].wen, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].wmask, mr, me);
            do_txn(tbl[i].wen, tbl[i].addr, tbl[i].size, tbl[i].wdata, tbl[i].wmask, 1'b0, r, e, lat);
            chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_lat", i), lat, 2);
        end

        // Reset in the middle of BUSY with a write to BASE pending
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE; req_size = 2'd2;
        req_wdata = 32'hCAFEF00D; req_wmask = 8'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midreset_valid_ready_async", {30'd0, valid_m, ready_m}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_valid_ready_held", {30'd0, valid_m, ready_m}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        do_txn(1'b0, BASE, 2'd2, 32'h0, 8'h0, 1'b0, r, e, lat);
        chk("midreset_write_dropped", r, 32'h11223344);

        // Backpressure: response held 5 cycles while a second request waits
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 8; req_size = 2'd2; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid_m) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("bp_resp_seen", {31'd0, ok}, 32'h1);
        r0 = rdata_m;
        chk("bp_rdata", r0, 32'h44AD5AEF);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 8; req_size = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid_ready", {30'd0, valid_m, ready_m}, 32'h2);
            chk("bp_hold_rdata", rdata_m, r0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_after_handshake_valid_ready", {30'd0, valid_m, ready_m}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'd0, ready_m}, 32'h0);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (valid_m) begin n = k; break; end
        end
        chk("bp_second_lat", n, 2);
        chk("bp_second_rdata", rdata_m, 32'h000000EF);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // LATENCY=1 and 15 instances: timing with resp_ready held early, then spacing
        for (int s = 1; s <= 2; s++) begin
            sel = 2'(s);
            run("lat_wr", 1'b1, BASE + 4, 2'd2, $urandom, 8'hF, 1'b1);
            run("lat_rd", 1'b0, BASE + 4, 2'd2, 32'h0, 8'h0, 1'b1);
            b2b(2'(s));
        end

        // Randomized traffic on the LATENCY=2 instance against the byte model
        sel = 2'd0;
        for (int i = 0; i < 16; i++)
            run("rnd_init", 1'b1, BASE + 32'h100 + 4 * i, 2'd2, $urandom, 8'hF, 1'b0);
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            if ($urandom_range(0, 7) == 0)
                a = $urandom_range(0, 1) ? BASE - 4 * $urandom_range(1, 8)
                                         : BASE + 4 * DEPTH + $urandom_range(0, 15);
            else
                a = BASE + 32'h100 + $urandom_range(0, 63);
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run("rnd", 1'($urandom_range(0, 1)), a, sz, $urandom, 8'($urandom),
                1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
